// File: rtl/sound_select_pio.sv
// -----------------------------------------------------------------------------
// sound_select_pio
//
// Avalon-MM input PIO for the sound-select switches and buttons. The external
// pins pass through a 2-flop synchroniser, then a per-bit debouncer that only
// accepts a new level after it has been seen continuously for DEBOUNCE_CYCLES
// clocks. Accepted level changes in the direction chosen by EDGE_TYPE set
// sticky edge-capture flags, which can raise a maskable level interrupt.
//
// Register map (word address):
//   0 DATA          RO     debounced stable value, writes ignored
//   1 reserved      RO     reads 0, writes ignored
//   2 IRQ_MASK      RW     per-bit interrupt enable
//   3 EDGE_CAPTURE  R/W1C  sticky edge flags, writing 1 clears a bit
//
// Bus handshake: a write is accepted on any rising clk edge where
// chipselect=1 and write_n=0; there is no wait request. There is no read
// strobe: readdata is reloaded from the addressed register on every clock,
// so read data is valid one clock after the address is presented (the
// interconnect is set up for one fixed read wait state).
//
// Parameters:
//   WIDTH            number of input bits (1..32)
//   DEBOUNCE_CYCLES  clocks a synchronised bit must differ from the stable
//                    value before it is accepted; 0 bypasses the debouncer
//   EDGE_TYPE        edge that sets a capture bit: 0 rising, 1 falling, 2 any
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   address     Avalon word address
//   chipselect  Avalon select, qualifies write
//   write_n     Avalon write strobe, active low
//   writedata   Avalon write data
//   in_port     asynchronous external inputs
//   readdata    registered Avalon read data
//   irq         level interrupt, |(edge_capture & irq_mask)
// -----------------------------------------------------------------------------
module sound_select_pio #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int EDGE_TYPE       = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [WIDTH-1:0] writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] readdata,
   output logic             irq
);

   // Counter is at least one bit wide so the bypass build still elaborates.
   localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST =
      (DEBOUNCE_CYCLES < 1) ? '0 : CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] stable;
   logic [CW-1:0]    cnt [WIDTH];
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] irq_mask;

   // ---------------------------------------------------------------------------
   // Next-state signals
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] stable_nxt;
   logic [CW-1:0]    cnt_nxt [WIDTH];
   logic [WIDTH-1:0] updated;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] edge_event;
   logic             wr_en;
   logic [WIDTH-1:0] w1c;
   logic [WIDTH-1:0] edge_capture_nxt;
   logic [WIDTH-1:0] irq_mask_nxt;
   logic [WIDTH-1:0] readdata_nxt;

   // ---------------------------------------------------------------------------
   // Debounce: a bit's counter runs only while sync2 disagrees with stable.
   // One clock of agreement restarts it, so short glitches never get through.
   // On the last count the new level is taken and the counter clears, so it
   // can never wrap.
   // ---------------------------------------------------------------------------
   always_comb begin
      stable_nxt = stable;
      for (int b = 0; b < WIDTH; b++) begin
         cnt_nxt[b] = '0;
      end
      if (DEBOUNCE_CYCLES == 0) begin
         stable_nxt = sync2;
      end else begin
         for (int b = 0; b < WIDTH; b++) begin
            if (sync2[b] != stable[b]) begin
               if (cnt[b] == CNT_LAST) begin
                  stable_nxt[b] = sync2[b];
               end else begin
                  cnt_nxt[b] = cnt[b] + CW'(1);
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Edge detection on accepted level changes and register updates
   // ---------------------------------------------------------------------------
   always_comb begin
      updated = stable_nxt ^ stable;
      rise    = updated & stable_nxt;
      fall    = updated & ~stable_nxt;
      case (EDGE_TYPE)
         0:       edge_event = rise;
         1:       edge_event = fall;
         default: edge_event = updated;
      endcase

      wr_en = chipselect & ~write_n;
      w1c   = (wr_en && (address == ADDR_EDGE)) ? writedata : '0;

      // Clear first, then OR in new events: a capture on the same edge as
      // a clearing write leaves the bit set, so no event is ever lost.
      edge_capture_nxt = (edge_capture & ~w1c) | edge_event;
      irq_mask_nxt     = (wr_en && (address == ADDR_MASK)) ? writedata : irq_mask;

      // Read mux uses current register values; the result appears next clock.
      case (address)
         ADDR_DATA: readdata_nxt = stable;
         ADDR_MASK: readdata_nxt = irq_mask;
         ADDR_EDGE: readdata_nxt = edge_capture;
         default:   readdata_nxt = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1        <= '0;
         sync2        <= '0;
         stable       <= '0;
         edge_capture <= '0;
         irq_mask     <= '0;
         readdata     <= '0;
         for (int b = 0; b < WIDTH; b++) begin
            cnt[b] <= '0;
         end
      end else begin
         sync1        <= in_port;
         sync2        <= sync1;
         stable       <= stable_nxt;
         edge_capture <= edge_capture_nxt;
         irq_mask     <= irq_mask_nxt;
         readdata     <= readdata_nxt;
         for (int b = 0; b < WIDTH; b++) begin
            cnt[b] <= cnt_nxt[b];
         end
      end
   end

   // Level interrupt straight from registers, no extra latency.
   assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_sound_select_pio.sv
// -----------------------------------------------------------------------------
// tb_sound_select_pio
//
// Two instances share every input: dut_r captures rising edges, dut_f falling
// edges (WIDTH=4, DEBOUNCE_CYCLES=4). The reference model keeps the history
// of pin samples and accepts a new level for a bit when the last D
// synchronised samples all differ from the current stable value.
// -----------------------------------------------------------------------------
module tb_sound_select_pio;

   localparam int W = 4;
   localparam int D = 4;

   // ---------------------------------------------------------------------------
   // Clock / reset and DUT
   // ---------------------------------------------------------------------------
   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   address;
   logic         chipselect;
   logic         write_n;
   logic [W-1:0] writedata;
   logic [W-1:0] in_port;
   logic [W-1:0] rd_r, rd_f;
   logic         irq_r, irq_f;

   always #5 clk = ~clk;

   sound_select_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) dut_r (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd_r), .irq(irq_r)
   );

   sound_select_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) dut_f (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd_f), .irq(irq_f)
   );

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   logic [W-1:0] pins[$];   // pins[i]: in_port sampled i+1 edges ago
   logic [W-1:0] m_stable, m_mask, m_cap_r, m_cap_f;
   logic [W-1:0] exp_rd_r, exp_rd_f;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Bits whose synchronised samples have disagreed with stable for D edges.
   function automatic logic [W-1:0] accept_mask();
      logic [W-1:0] acc;
      acc = '1;
      for (int i = 1; i <= D; i++) acc &= pins[i] ^ m_stable;
      return acc;
   endfunction

   function automatic logic [W-1:0] reg_read(input logic [1:0] a, input logic [W-1:0] cap);
      case (a)
         2'd0:    return m_stable;
         2'd2:    return m_mask;
         2'd3:    return cap;
         default: return '0;
      endcase
   endfunction

   task automatic model_edge();
      logic [W-1:0] acc, ns, w1c;
      logic         wr;
      if (reset) begin
         m_stable = '0; m_mask = '0; m_cap_r = '0; m_cap_f = '0;
         exp_rd_r = '0; exp_rd_f = '0;
         pins.delete();
         for (int i = 0; i <= D; i++) pins.push_back('0);
      end else begin
         exp_rd_r = reg_read(address, m_cap_r);
         exp_rd_f = reg_read(address, m_cap_f);
         acc = accept_mask();
         ns  = m_stable ^ acc;
         wr  = chipselect && !write_n;
         w1c = (wr && address == 2'd3) ? writedata : '0;
         m_cap_r = (m_cap_r & ~w1c) | (acc & ns);
         m_cap_f = (m_cap_f & ~w1c) | (acc & ~ns);
         if (wr && address == 2'd2) m_mask = writedata;
         m_stable = ns;
         pins.push_front(in_port);
         void'(pins.pop_back());
      end
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks: drive at negedge, check #1 after posedge
   // ---------------------------------------------------------------------------
   task automatic step(input logic r, input logic [1:0] a, input logic cs,
                       input logic wn, input logic [W-1:0] wd, input logic [W-1:0] p);
      @(negedge clk);
      reset = r; address = a; chipselect = cs; write_n = wn; writedata = wd; in_port = p;
      @(posedge clk);
      model_edge();
      #1;
      check("rd_rise", rd_r, exp_rd_r);
      check("rd_fall", rd_f, exp_rd_f);
      check("irq_rise", irq_r, |(m_cap_r & m_mask));
      check("irq_fall", irq_f, |(m_cap_f & m_mask));
   endtask

   task automatic idle(input logic [W-1:0] p, input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 1'b1, '0, p);
   endtask

   task automatic rd(input logic [1:0] a, input logic [W-1:0] p);
      step(1'b0, a, 1'b0, 1'b1, '0, p);
   endtask

   task automatic wr(input logic [1:0] a, input logic [W-1:0] d, input logic [W-1:0] p);
      step(1'b0, a, 1'b1, 1'b0, d, p);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic [W-1:0] pin;
      bit           hit;

      reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; in_port = '0;

      // 1: reset with all pins high, then release and hold
      step(1'b1, 2'd0, 1'b0, 1'b1, '0, 4'hF);
      step(1'b1, 2'd0, 1'b0, 1'b1, '0, 4'hF);
      check("t1_reset_rd", rd_r, 4'h0);
      check("t1_reset_irq", irq_r, 1'b0);
      idle(4'hF, 6);                       // stable flips at edge 6
      check("t1_before", rd_r, 4'h0);
      idle(4'hF, 1);
      check("t1_data", rd_r, 4'hF);
      rd(2'd3, 4'hF);
      check("t1_edge", rd_r, 4'hF);
      wr(2'd3, 4'hF, 4'hF);

      // 2: three-clock glitch on bit0 is rejected
      idle(4'h0, 10);
      wr(2'd3, 4'hF, 4'h0);
      idle(4'h1, 3);
      idle(4'h0, 10);
      rd(2'd0, 4'h0);
      check("t2_data", rd_r, 4'h0);
      rd(2'd3, 4'h0);
      check("t2_edge", rd_r, 4'h0);

      // 3: masked capture raises irq, W1C drops it
      wr(2'd2, 4'h2, 4'h0);
      idle(4'h2, 8);
      rd(2'd3, 4'h2);
      check("t3_edge", rd_r, 4'h2);
      check("t3_irq", irq_r, 1'b1);
      wr(2'd3, 4'h2, 4'h2);
      check("t3_irq_clr", irq_r, 1'b0);
      rd(2'd3, 4'h2);
      check("t3_edge_clr", rd_r, 4'h0);

      // 4: W1C lands on the exact capture edge
      idle(4'h0, 8);
      wr(2'd3, 4'hF, 4'h0);
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         if (accept_mask()[1]) begin
            wr(2'd3, 4'h2, 4'h2);
            hit = 1'b1;
         end else begin
            idle(4'h2, 1);
         end
      end
      check("t4_reached", hit, 1'b1);
      check("t4_irq", irq_r, 1'b1);
      rd(2'd3, 4'h2);
      check("t4_edge", rd_r, 4'h2);

      // 5: falling-edge instance
      idle(4'h1, 8);
      wr(2'd3, 4'hF, 4'h1);
      idle(4'h0, 8);
      rd(2'd3, 4'h0);
      check("t5_fall", rd_f, 4'h1);
      wr(2'd3, 4'hF, 4'h0);
      idle(4'h1, 8);
      rd(2'd3, 4'h1);
      check("t5_rise_ignored", rd_f, 4'h0);

      // 6: writes to DATA and reserved are ignored
      wr(2'd2, 4'h9, 4'h1);
      wr(2'd0, 4'h5, 4'h1);
      wr(2'd1, 4'h5, 4'h1);
      rd(2'd0, 4'h1);
      check("t6_data", rd_r, 4'h1);
      rd(2'd1, 4'h1);
      check("t6_resv", rd_r, 4'h0);
      rd(2'd2, 4'h1);
      check("t6_mask", rd_r, 4'h9);

      // Random traffic: pins with random hold lengths, random bus ops,
      // occasional reset mid-debounce.
      pin = 4'h1;
      for (int i = 0; i < 3000; i++) begin
         int act;
         if ($urandom_range(0, 5) == 0) pin = W'($urandom);
         act = int'($urandom_range(0, 99));
         if (act == 0)
            step(1'b1, 2'($urandom), 1'b0, 1'b1, '0, pin);
         else if (act < 20)
            step(1'b0, 2'($urandom), 1'($urandom), 1'b0, W'($urandom), pin);
         else
            rd(2'($urandom), pin);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
